two_port_mem_fifo: RTL and testbench



---
 rtl/two_port_mem_fifo_pkg.sv | 12 +
 rtl/twoPortMem.sv | 39 +++
 rtl/two_port_mem_fifo_wrap_ptr.sv | 33 +++
 rtl/two_port_mem_fifo.sv | 115 +++++++++++
 tb/tb_two_port_mem_fifo.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/two_port_mem_fifo_pkg.sv
// rtl/two_port_mem_fifo_pkg.sv - shared sizing helper for the two-port-memory FIFO
// Provides clogb2(n): the number of bits needed to encode n distinct values (minimum 1).
package two_port_mem_fifo_pkg;

  function automatic int clogb2(input int n);
    for (int b = 1; b < 31; b++) begin
      if ((1 << b) >= n) return b;
    end
    return 31;
  endfunction

endpackage

// File: rtl/twoPortMem.sv
// rtl/twoPortMem.sv - one-write/one-read port word memory with registered read data
// Ports:
//   writeClk, writeEnable, writeAddress, writeData : write port, captured at posedge writeClk
//   readClk, readEnable, readAddress               : read request, sampled at posedge readClk
//   readData                                       : word read by the last sampled request; holds otherwise
module twoPortMem #(
  parameter int addresses    = 32,
  parameter int width        = 8,
  parameter int muxFactor    = 0,
  parameter int addressWidth = 5
) (
  input  logic                    writeClk,
  input  logic                    writeEnable,
  input  logic [addressWidth-1:0] writeAddress,
  input  logic [width-1:0]        writeData,
  input  logic                    readClk,
  input  logic                    readEnable,
  input  logic [addressWidth-1:0] readAddress,
  output logic [width-1:0]        readData
);

  logic [width-1:0] mem_q [addresses];
  logic [width-1:0] read_data_q;

  // Column muxing only changes the physical macro layout, not the behaviour.
  if (muxFactor < 0) begin : g_mux_factor_unused
  end

  always_ff @(posedge writeClk) begin
    if (writeEnable) mem_q[writeAddress] <= writeData;
  end

  always_ff @(posedge readClk) begin
    if (readEnable) read_data_q <= mem_q[readAddress];
  end

  assign readData = read_data_q;

endmodule

// File: rtl/two_port_mem_fifo_wrap_ptr.sv
// rtl/two_port_mem_fifo_wrap_ptr.sv - address pointer that counts 0..addresses-1 and wraps
// Ports:
//   clk, rstN : clock, asynchronous active-low reset (pointer returns to 0)
//   inc_i     : advance the pointer at the next posedge
//   ptr_o     : current pointer value
module wrap_ptr #(
  parameter int addresses    = 32,
  parameter int addressWidth = 5
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic                    inc_i,
  output logic [addressWidth-1:0] ptr_o
);

  localparam logic [addressWidth-1:0] LastAddr = addressWidth'(addresses - 1);

  logic [addressWidth-1:0] ptr_q, ptr_d;

  // Explicit wrap so non-power-of-two depths never index past the last word.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = (ptr_q == LastAddr) ? '0 : ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/two_port_mem_fifo.sv
// rtl/two_port_mem_fifo.sv - first-word-fall-through FIFO built on one twoPortMem
// Optional feature macro: TWO_PORT_MEM_FIFO_HIGHWATER_EN adds the highWater output.
// Ports:
//   clk, rstN                      : single clock, asynchronous active-low reset
//   pushValid, pushReady, pushData : producer handshake; a word is taken when both are high
//   popValid, popReady, popData    : consumer handshake; popData is the head word while popValid
//   count                          : words held in memory plus the head word (max addresses+1)
//   highWater (optional)           : largest count seen since reset
module two_port_mem_fifo
  import two_port_mem_fifo_pkg::*;
#(
  parameter  int addresses    = 32,
  parameter  int width        = 8,
  parameter  int muxFactor    = 0,
  localparam int addressWidth = clogb2(addresses),
  localparam int countWidth   = clogb2(addresses + 2)
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  pushValid,
  output logic                  pushReady,
  input  logic [width-1:0]      pushData,
  output logic                  popValid,
  input  logic                  popReady,
  output logic [width-1:0]      popData,
  output logic [countWidth-1:0] count
`ifdef TWO_PORT_MEM_FIFO_HIGHWATER_EN
  ,
  output logic [countWidth-1:0] highWater
`endif
);

  localparam logic [countWidth-1:0] Depth = countWidth'(addresses);

  logic [addressWidth-1:0] wr_ptr, rd_ptr;
  logic [countWidth-1:0]   mem_count_q, mem_count_d;
  logic                    head_valid_q, head_valid_d;
  logic                    push, read_en;

  // Only registered state feeds pushReady, so it never waits on popReady.
  assign pushReady = (mem_count_q < Depth);
  assign push      = pushValid && pushReady;

  // Refill the head whenever it is empty or being consumed this cycle.
  assign read_en = (mem_count_q != '0) && (!head_valid_q || popReady);

  always_comb begin
    mem_count_d  = mem_count_q + countWidth'(push) - countWidth'(read_en);
    head_valid_d = read_en ? 1'b1 : (popReady ? 1'b0 : head_valid_q);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mem_count_q  <= '0;
      head_valid_q <= 1'b0;
    end else begin
      mem_count_q  <= mem_count_d;
      head_valid_q <= head_valid_d;
    end
  end

  assign popValid = head_valid_q;
  assign count    = mem_count_q + countWidth'(head_valid_q);

`ifdef TWO_PORT_MEM_FIFO_HIGHWATER_EN
  logic [countWidth-1:0] high_water_q, count_d;

  assign count_d = mem_count_d + countWidth'(head_valid_d);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)                       high_water_q <= '0;
    else if (count_d > high_water_q) high_water_q <= count_d;
  end

  assign highWater = high_water_q;
`endif

  wrap_ptr #(
    .addresses   (addresses),
    .addressWidth(addressWidth)
  ) u_wr_ptr (
    .clk  (clk),
    .rstN (rstN),
    .inc_i(push),
    .ptr_o(wr_ptr)
  );

  wrap_ptr #(
    .addresses   (addresses),
    .addressWidth(addressWidth)
  ) u_rd_ptr (
    .clk  (clk),
    .rstN (rstN),
    .inc_i(read_en),
    .ptr_o(rd_ptr)
  );

  // Read data stays valid while readEnable is low, which is what holds popData during a stall.
  twoPortMem #(
    .addresses   (addresses),
    .width       (width),
    .muxFactor   (muxFactor),
    .addressWidth(addressWidth)
  ) u_mem (
    .writeClk    (clk),
    .writeEnable (push),
    .writeAddress(wr_ptr),
    .writeData   (pushData),
    .readClk     (clk),
    .readEnable  (read_en),
    .readAddress (rd_ptr),
    .readData    (popData)
  );

endmodule

// File: tb/tb_two_port_mem_fifo.sv
// tb/tb_two_port_mem_fifo.sv - self-checking bench for two_port_mem_fifo (depths 32 and 5)
module tb_two_port_mem_fifo;
  localparam int W      = 8;
  localparam int DEPTH0 = 32;
  localparam int DEPTH1 = 5;

  typedef struct {
    int           dut;
    logic [W-1:0] val;
    int           t;
  } ent_t;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  logic         pv [2];
  logic [W-1:0] pd [2];
  logic         pr [2];
  logic         prdy0, prdy1, popv0, popv1;
  logic [W-1:0] popd0, popd1;
  logic [5:0]   cnt0;
  logic [2:0]   cnt1;
`ifdef TWO_PORT_MEM_FIFO_HIGHWATER_EN
  logic [5:0]   hw0;
  logic [2:0]   hw1;
  int           m_hw [2];
`endif

  int           n_cmp = 0;
  int           n_fail = 0;
  int           cyc = 0;
  ent_t         mq[$];
  logic [W-1:0] popped0[$];
  logic [W-1:0] popped1[$];

  two_port_mem_fifo #(.addresses(DEPTH0), .width(W), .muxFactor(0)) u_dut0 (
    .clk(clk), .rstN(rstN),
    .pushValid(pv[0]), .pushReady(prdy0), .pushData(pd[0]),
    .popValid(popv0), .popReady(pr[0]), .popData(popd0),
    .count(cnt0)
`ifdef TWO_PORT_MEM_FIFO_HIGHWATER_EN
    , .highWater(hw0)
`endif
  );

  two_port_mem_fifo #(.addresses(DEPTH1), .width(W), .muxFactor(0)) u_dut1 (
    .clk(clk), .rstN(rstN),
    .pushValid(pv[1]), .pushReady(prdy1), .pushData(pd[1]),
    .popValid(popv1), .popReady(pr[1]), .popData(popd1),
    .count(cnt1)
`ifdef TWO_PORT_MEM_FIFO_HIGHWATER_EN
    , .highWater(hw1)
`endif
  );

  // ---------------- model: an ordered list of held words with arrival times ----------------
  function automatic int depth(int d);
    return (d == 0) ? DEPTH0 : DEPTH1;
  endfunction

  function automatic int m_size(int d);
    int n = 0;
    foreach (mq[i]) if (mq[i].dut == d) n++;
    return n;
  endfunction

  function automatic int m_head(int d);
    foreach (mq[i]) if (mq[i].dut == d) return i;
    return -1;
  endfunction

  // The oldest word is presented once at least one full edge has passed since it arrived.
  function automatic bit m_pv(int d);
    int h = m_head(d);
    return (h >= 0) && (mq[h].t < cyc);
  endfunction

  // Memory capacity excludes the word already presented at the head.
  function automatic bit m_prdy(int d);
    return (m_size(d) - int'(m_pv(d))) < depth(d);
  endfunction

  function automatic logic [31:0] dut_pv(int d);
    return (d == 0) ? 32'(popv0) : 32'(popv1);
  endfunction
  function automatic logic [31:0] dut_prdy(int d);
    return (d == 0) ? 32'(prdy0) : 32'(prdy1);
  endfunction
  function automatic logic [31:0] dut_cnt(int d);
    return (d == 0) ? 32'(cnt0) : 32'(cnt1);
  endfunction
  function automatic logic [31:0] dut_popd(int d);
    return (d == 0) ? 32'(popd0) : 32'(popd1);
  endfunction
`ifdef TWO_PORT_MEM_FIFO_HIGHWATER_EN
  function automatic logic [31:0] dut_hw(int d);
    return (d == 0) ? 32'(hw0) : 32'(hw1);
  endfunction
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rstN);
      if (!rstN) begin
        mq.delete();
`ifdef TWO_PORT_MEM_FIFO_HIGHWATER_EN
        m_hw[0] = 0;
        m_hw[1] = 0;
`endif
      end else begin
        bit do_push [2];
        bit do_pop [2];
        for (int d = 0; d < 2; d++) begin
          do_push[d] = pv[d] && m_prdy(d);
          do_pop[d]  = pr[d] && m_pv(d);
        end
        if (popv0 && pr[0]) popped0.push_back(popd0);
        if (popv1 && pr[1]) popped1.push_back(popd1);
        cyc++;
        for (int d = 0; d < 2; d++) if (do_pop[d]) mq.delete(m_head(d));
        for (int d = 0; d < 2; d++) if (do_push[d]) mq.push_back('{d, pd[d], cyc});
`ifdef TWO_PORT_MEM_FIFO_HIGHWATER_EN
        for (int d = 0; d < 2; d++) if (m_size(d) > m_hw[d]) m_hw[d] = m_size(d);
`endif
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        bit ev;
        ev = m_pv(d);
        chk($sformatf("popValid[%0d]", d), dut_pv(d), 32'(ev));
        chk($sformatf("pushReady[%0d]", d), dut_prdy(d), 32'(m_prdy(d)));
        chk($sformatf("count[%0d]", d), dut_cnt(d), 32'(m_size(d)));
        if (ev) chk($sformatf("popData[%0d]", d), dut_popd(d), 32'(mq[m_head(d)].val));
`ifdef TWO_PORT_MEM_FIFO_HIGHWATER_EN
        chk($sformatf("highWater[%0d]", d), dut_hw(d), 32'(m_hw[d]));
`endif
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      pv[d] = 1'b0;
      pd[d] = '0;
      pr[d] = 1'b0;
    end
    idle(2);
    chk("reset count", 32'(cnt0), 0);
    chk("reset pushReady", 32'(prdy0), 1);
    chk("reset popValid", 32'(popv0), 0);
    rstN = 1'b1;
    idle(1);

    // single word with a 3-cycle stall
    pv[0] = 1'b1; pd[0] = 8'h3C; tick(); pv[0] = 1'b0;
    chk("single not yet valid", 32'(popv0), 0);
    tick();
    chk("single popValid", 32'(popv0), 1);
    chk("single popData", 32'(popd0), 32'h3C);
    chk("single count", 32'(cnt0), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("single stall data", 32'(popd0), 32'h3C);
    end
    pr[0] = 1'b1; tick(); pr[0] = 1'b0;
    chk("single popped valid", 32'(popv0), 0);
    chk("single popped count", 32'(cnt0), 0);

    // fill to capacity, overflow attempt, full with simultaneous pop, drain
    popped0.delete();
    for (int i = 0; i < 33; i++) begin
      pv[0] = 1'b1; pd[0] = 8'(i); tick();
    end
    chk("fill count", 32'(cnt0), 33);
    chk("fill pushReady", 32'(prdy0), 0);
    pd[0] = 8'hFF; tick();
    chk("overflow count", 32'(cnt0), 33);
    pd[0] = 8'hEE; pr[0] = 1'b1; tick(); pr[0] = 1'b0;
    chk("full+pop count", 32'(cnt0), 32);
    chk("full+pop pushReady", 32'(prdy0), 1);
    tick(); pv[0] = 1'b0;
    chk("refill count", 32'(cnt0), 33);
    chk("refill pushReady", 32'(prdy0), 0);
    pr[0] = 1'b1; idle(40); pr[0] = 1'b0;
    chk("drain count", 32'(cnt0), 0);
    chk("drain words", 32'(popped0.size()), 34);
    for (int i = 0; i < 34; i++)
      if (i < popped0.size()) chk("drain order", 32'(popped0[i]), (i < 33) ? 32'(i) : 32'hEE);

    // streaming at one word per cycle
    popped0.delete();
    pr[0] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      pv[0] = 1'b1; pd[0] = 8'(i); tick();
      if (i == 50) begin
        chk("stream count", 32'(cnt0), 2);
        chk("stream rate", 32'(popped0.size()), 49);
      end
    end
    pv[0] = 1'b0; idle(4); pr[0] = 1'b0;
    chk("stream words", 32'(popped0.size()), 100);
    for (int i = 0; i < 100; i++)
      if (i < popped0.size()) chk("stream order", 32'(popped0[i]), 32'(i));

    // asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) begin
      pv[0] = 1'b1; pd[0] = 8'h50 + 8'(i); tick();
    end
    pv[0] = 1'b0;
    chk("pre-reset count", 32'(cnt0), 5);
    #2 rstN = 1'b0;
    #1;
    chk("async reset count", 32'(cnt0), 0);
    chk("async reset popValid", 32'(popv0), 0);
    chk("async reset pushReady", 32'(prdy0), 1);
    tick(); rstN = 1'b1;
    popped0.delete();
    pv[0] = 1'b1; pd[0] = 8'hA5; tick(); pv[0] = 1'b0; pr[0] = 1'b1;
    tick();
    chk("post-reset popValid", 32'(popv0), 1);
    chk("post-reset popData", 32'(popd0), 32'hA5);
    tick(); pr[0] = 1'b0;
    chk("post-reset popped", 32'(popped0.size()), 1);
    if (popped0.size() > 0) chk("post-reset word", 32'(popped0[0]), 32'hA5);
    chk("post-reset count", 32'(cnt0), 0);

    // depth-5 wrap-around with push/pop stalls
    begin : wrap_test
      logic [15:0] ppat;
      logic [15:0] qpat;
      int          sent;
      int          budget;
      ppat   = 16'b1101_1111_0110_1111;
      qpat   = 16'b0011_0100_1101_0010;
      sent   = 0;
      budget = 0;
      popped1.delete();
      while (popped1.size() < 12 && budget < 300) begin
        pv[1] = (sent < 12) && ppat[budget % 16];
        pd[1] = 8'h10 + 8'(sent);
        pr[1] = qpat[budget % 16] || (sent == 12);
        if (pv[1] && prdy1) sent++;
        tick();
        budget++;
      end
      pv[1] = 1'b0; pr[1] = 1'b0;
      tick();
      chk("wrap within budget", 32'(budget < 300), 1);
      chk("wrap words", 32'(popped1.size()), 12);
      for (int i = 0; i < 12; i++)
        if (i < popped1.size()) chk("wrap order", 32'(popped1[i]), 32'h10 + 32'(i));
      chk("wrap final count", 32'(cnt1), 0);
    end

    idle(2);
    summary();
    $finish;
  end

  initial begin
    #50000;
    n_fail++;
    $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
    summary();
    $finish;
  end

endmodule
